// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    localparam addr_t INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; the head is visible combinationally.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, buffered into fetch_fifo, with redirect/drop handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise misalign_err and halt fetch.
module instr_fetch
    import mips_pkg::*;
#(
    parameter addr_t RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        misalign_err
);

    fetch_state_e state;
    addr_t        fetch_pc;
    addr_t        req_pc;
    logic         fetch_en;
    addr_t        redirect_target;
    logic         misaligned;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;
    assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            misalign_err <= 1'b1;
        end
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign misaligned      = 1'b0;
    assign misalign_err    = 1'b0;
`endif

    // fetch_en keeps mem_req low while reset is held and for the cycle it releases.
    assign mem_req    = fetch_en && (state == ST_REQ) && !fifo_full;
    assign mem_addr   = fetch_pc;
    assign fifo_push  = (state == ST_WAIT) && mem_rvalid && !redirect_valid;
    assign fifo_pop   = if_valid && if_ready;
    assign push_entry = '{pc: req_pc, instr: mem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            fetch_en <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                if (misaligned) begin
                    state <= ST_HALT;
                end else begin
                    // A granted-but-unanswered request must have its response discarded.
                    case (state)
                        ST_REQ:  state <= (mem_req && mem_gnt) ? ST_DROP : ST_REQ;
                        ST_WAIT: state <= mem_rvalid ? ST_REQ : ST_DROP;
                        ST_DROP: state <= mem_rvalid ? ST_REQ : ST_DROP;
                        default: state <= ST_REQ;
                    endcase
                end
            end else begin
                case (state)
                    ST_REQ: begin
                        if (mem_req && mem_gnt) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + INSTR_BYTES;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: if (mem_rvalid) state <= ST_REQ;
                    ST_DROP: if (mem_rvalid) state <= ST_REQ;
                    default: state <= state;
                endcase
            end
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = fifo_head.pc;
    assign if_instr = fifo_head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch (FIFO_DEPTH=2, RESET_PC=0); honours FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_ready      (if_ready),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs across the next rising edge; return at the following falling edge.
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic gnt,
                                 input logic rvld, input logic [31:0] rdata, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_gnt        = gnt;
        mem_rvalid     = rvld;
        mem_rdata      = rdata;
        if_ready       = rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        logic [31:0] data;

        repeat (2) @(negedge clk);
        checkOutput("rst mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        checkOutput("rst if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst if_instr", if_instr, 32'h0);
        checkOutput("rst if_pc", if_pc, 32'h0);
        checkOutput("rst misalign", 32'(misalign_err), 32'd0);

        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post-rst mem_req", 32'(mem_req), 32'd1);
        checkOutput("post-rst mem_addr", mem_addr, 32'h0);

        // Streaming: one instruction every two cycles, pcs 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            data = 32'hA000_0000 + 32'(i);
            checkOutput("stream mem_addr", mem_addr, 32'(i * 4));
            applyStimulus(0, 0, 1, 0, 0, 1);
            checkOutput("stream wait mem_req", 32'(mem_req), 32'd0);
            applyStimulus(0, 0, 0, 1, data, 1);
            checkOutput("stream if_valid", 32'(if_valid), 32'd1);
            checkOutput("stream if_pc", if_pc, 32'(i * 4));
            checkOutput("stream if_instr", if_instr, data);
        end

        // Backpressure: FIFO fills after two pushes
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain if_valid", 32'(if_valid), 32'd0);
        checkOutput("ungranted addr hold", mem_addr, 32'h10);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hB000_0001, 0);
        checkOutput("bp 1 push mem_req", 32'(mem_req), 32'd1);
        checkOutput("bp 1 push addr", mem_addr, 32'h14);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hB000_0002, 0);
        checkOutput("bp full mem_req", 32'(mem_req), 32'd0);
        checkOutput("bp full if_pc", if_pc, 32'h10);
        checkOutput("bp full if_instr", if_instr, 32'hB000_0001);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("bp stall mem_req", 32'(mem_req), 32'd0);
        checkOutput("bp stall addr", mem_addr, 32'h18);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("bp pulse mem_req", 32'(mem_req), 32'd1);
        checkOutput("bp pulse if_pc", if_pc, 32'h14);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hB000_0003, 0);
        checkOutput("bp refill mem_req", 32'(mem_req), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("bp drain if_pc", if_pc, 32'h18);
        checkOutput("bp drain if_instr", if_instr, 32'hB000_0003);
        checkOutput("bp drain addr", mem_addr, 32'h1C);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("bp empty if_valid", 32'(if_valid), 32'd0);

        // Redirect in WAIT: pending response dropped
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0);
        checkOutput("drop mem_req", 32'(mem_req), 32'd0);
        applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        checkOutput("drop if_valid", 32'(if_valid), 32'd0);
        checkOutput("drop resume addr", mem_addr, 32'h100);
        checkOutput("drop resume req", 32'(mem_req), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hCAFE_0001, 0);
        checkOutput("redir if_pc", if_pc, 32'h100);
        checkOutput("redir if_instr", if_instr, 32'hCAFE_0001);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("redir next addr", mem_addr, 32'h104);

        // Redirect against an ungranted request: withdrawn, no DROP
        applyStimulus(1, 32'h8, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ungranted at 8", mem_addr, 32'h8);
        applyStimulus(1, 32'h40, 0, 0, 0, 0);
        checkOutput("withdraw addr", mem_addr, 32'h40);
        checkOutput("withdraw mem_req", 32'(mem_req), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h1234_5678, 0);
        checkOutput("withdraw if_pc", if_pc, 32'h40);

        // Redirect with same-cycle grant and pop -> DROP, FIFO flushed
        applyStimulus(1, 32'h80, 1, 0, 0, 1);
        checkOutput("gnt-redir mem_req", 32'(mem_req), 32'd0);
        checkOutput("gnt-redir if_valid", 32'(if_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 32'h0BAD_0BAD, 0);
        checkOutput("gnt-redir discard", 32'(if_valid), 32'd0);
        checkOutput("gnt-redir addr", mem_addr, 32'h80);

        // Redirect beats a same-cycle response
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(1, 32'hC0, 0, 1, 32'h0BAD_0BAD, 0);
        checkOutput("rvalid-redir if_valid", 32'(if_valid), 32'd0);
        checkOutput("rvalid-redir mem_req", 32'(mem_req), 32'd1);
        checkOutput("rvalid-redir addr", mem_addr, 32'hC0);

        // Address wrap at the top of memory
        applyStimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        checkOutput("wrap start addr", mem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("wrap next addr", mem_addr, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h7777_0000, 0);
        checkOutput("wrap if_pc", if_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 1);

`ifdef FETCH_ALIGN_CHECK_EN
        applyStimulus(1, 32'h102, 0, 0, 0, 0);
        checkOutput("misalign err", 32'(misalign_err), 32'd1);
        checkOutput("misalign mem_req", 32'(mem_req), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("halt mem_req", 32'(mem_req), 32'd0);
        applyStimulus(1, 32'h200, 0, 0, 0, 0);
        checkOutput("resume mem_req", 32'(mem_req), 32'd1);
        checkOutput("resume addr", mem_addr, 32'h200);
        checkOutput("sticky err", 32'(misalign_err), 32'd1);
`else
        applyStimulus(1, 32'h102, 0, 0, 0, 0);
        checkOutput("align force addr", mem_addr, 32'h100);
        checkOutput("align err tied", 32'(misalign_err), 32'd0);
        checkOutput("align mem_req", 32'(mem_req), 32'd1);
`endif

        // Reset mid-transaction, then a stray response is ignored
        applyStimulus(0, 0, 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        checkOutput("midrst mem_req", 32'(mem_req), 32'd0);
        checkOutput("midrst addr", mem_addr, 32'h0);
        checkOutput("midrst misalign", 32'(misalign_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'h5555_AAAA, 0);
        checkOutput("stray if_valid", 32'(if_valid), 32'd0);
        checkOutput("stray mem_req", 32'(mem_req), 32'd1);
        applyStimulus(0, 0, 0, 1, 32'h5555_AAAA, 0);
        checkOutput("stray2 if_valid", 32'(if_valid), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_0013, 0);
        checkOutput("post-rst if_pc", if_pc, 32'h0);
        checkOutput("post-rst if_instr", if_instr, 32'h0000_0013);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: number of buffered {pc, instr} entries; legal values 2 or 4.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address, the branch adder output.
REQ-007 mem_req  output  1  instruction-memory read request.
REQ-008 mem_addr  output  32  word address of request.
REQ-009 mem_gnt  input  1  request accepted this cycle.
REQ-010 mem_rvalid  input  1  read data valid.
REQ-011 mem_rdata  input  32  instruction word.
REQ-012 if_valid  output  1  instruction available to decode.
REQ-013 if_instr  output  32  instruction word.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_ready  input  1  decode accepts; transfer on if_valid && if_ready.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 States: REQ (mem_req=1), WAIT (granted, awaiting rvalid), DROP (granted response to discard), HALT (misalign stop).
REQ-018 At most one request outstanding; mem_rvalid arrives >=1 cycle after mem_gnt.
REQ-019 REQ entered only when FIFO occupancy < FIFO_DEPTH; otherwise mem_req=0 until a pop frees a slot.
REQ-020 In REQ, mem_addr = fetch_pc; on mem_gnt: fetch_pc <= fetch_pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), state -> WAIT.
REQ-021 In WAIT, on mem_rvalid: push {request address, mem_rdata}; state -> REQ if space remains after push, else idle in REQ with mem_req=0.
REQ-022 FIFO output drives if_valid/if_instr/if_pc directly; zero-cycle latency from head to output; mem_rvalid to if_valid latency 1 cycle.
REQ-023 Simultaneous push and pop when full: both occur; occupancy unchanged.
REQ-024 redirect_valid: FIFO flushed next cycle, fetch_pc <= redirect_pc; redirect overrides same-cycle mem_rvalid push and if handshake (pop counted, data irrelevant).
REQ-025 Redirect in REQ without mem_gnt: request withdrawn, next cycle REQ with new address (ungranted withdrawal permitted).
REQ-026 Redirect in REQ with same-cycle mem_gnt, or in WAIT without mem_rvalid: state -> DROP; next mem_rvalid discarded, then -> REQ.
REQ-027 Redirect in DROP: fetch_pc updated, remain DROP.
REQ-028 mem_addr held stable while mem_req=1 and mem_gnt=0, except REQ-025 withdrawal.

Reset
REQ-029 During rst: mem_req=0, mem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, misalign_err=0, FIFO empty, fetch_pc=RESET_PC, state REQ.
REQ-030 First rising edge after rst deasserts: mem_req=1 with mem_addr=RESET_PC.
REQ-031 rst mid-transaction abandons outstanding response; a post-reset stray mem_rvalid while in REQ is ignored.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets misalign_err (sticky until rst), flushes, enters HALT (mem_req=0) until next aligned redirect, which resumes fetch.
REQ-033 Macro undefined: redirect_pc[1:0] forced to 2'b00, misalign_err tied 0, HALT absent.

Structure
REQ-034 Package mips_pkg holds addr_t, instr_t (32-bit), fetch_state_e, INSTR_BYTES=4.
REQ-035 Sub-module fetch_fifo: synchronous FIFO of {addr_t, instr_t}, push/pop/flush, full/empty, parameter FIFO_DEPTH.

Verification
REQ-036 Reset release, mem_gnt=1, rvalid 1 cycle later, if_ready=1 -> if_pc sequence 0,4,8,C; one instruction per 2 cycles.
REQ-037 if_ready=0 with FIFO_DEPTH=2 -> exactly 2 pushes, mem_req=0 afterward; single if_ready pulse -> one new request.
REQ-038 redirect_pc=32'h100 while in WAIT -> pending rvalid data (0xDEADBEEF) never appears; next if_pc=0x100.
REQ-039 Redirect concurrent with ungranted request at 0x8 -> next-cycle mem_addr=redirect target, no DROP.
REQ-040 fetch_pc=32'hFFFF_FFFC granted -> next mem_addr=0.
REQ-041 FETCH_ALIGN_CHECK_EN, redirect_pc=0x102 -> misalign_err=1, mem_req=0; redirect 0x200 -> fetch resumes, misalign_err stays 1.
